// File: rtl/func_seq_pkg.sv
// Shared types for the func sequencer: FSM states, instruction word layout, HALT code.
package func_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  typedef struct packed {
    logic [3:0] rpt;
    logic [3:0] func;
  } instr_t;

  localparam logic [3:0] HALT_FUNC = 4'hF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Gating on the registered flags refuses a write when full and a read when empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/func_sequencer.sv
// Issues buffered func codes to the datapath controller, each repeated R+1 times,
// stopping on HALT or an empty queue until the next start pulse.
module func_sequencer
  import func_seq_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [3:0]  HALT_CODE = HALT_FUNC,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [7:0]       load_data,
  input  logic             start,
  output logic [3:0]       func_out,
  output logic             func_valid,
  input  logic             func_ready,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] issue_count
);

  state_t     state;
  logic [3:0] rem;
  instr_t     head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign load_ready = !fifo_full;
  assign pop        = (state == FETCH) && !fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(instr_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (load_valid),
    .wdata (load_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      func_out    <= '0;
      func_valid  <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      issue_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (fifo_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (head.func == HALT_CODE) begin
            halted <= 1'b1;
            busy   <= 1'b0;
            state  <= HALTED;
          end else begin
            func_out   <= head.func;
            rem        <= head.rpt;
            func_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (func_ready) begin
            issue_count <= issue_count + CNT_W'(1);
            if (rem != 4'd0) begin
              rem <= rem - 4'd1;
            end else begin
              func_valid <= 1'b0;
              state      <= FETCH;
            end
          end
        end
        HALTED: begin
          if (start) begin
            halted <= 1'b0;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_sequencer.sv
// Directed bench for func_sequencer with hand-computed expectations.
module tb_func_sequencer;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        start;
  logic [3:0]  func_out;
  logic        func_valid;
  logic        func_ready;
  logic        busy;
  logic        halted;
  logic [15:0] issue_count;

  int n_checks;
  int n_fail;
  logic [15:0] exp_count;

  func_sequencer #(
    .DEPTH     (8),
    .HALT_CODE (4'hF),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .start       (start),
    .func_out    (func_out),
    .func_valid  (func_valid),
    .func_ready  (func_ready),
    .busy        (busy),
    .halted      (halted),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0; func_ready = 1'b0;
    #12;
    n_checks++;
    if ({load_ready, func_out, func_valid, busy, halted} !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%0b out=%h val=%0b busy=%0b halt=%0b, want 1 0 0 0 0",
               load_ready, func_out, func_valid, busy, halted);
    end
    n_checks++;
    if (issue_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", issue_count);
    end
    rst_n = 1'b1;
    tick();
    exp_count = 16'd0;
  endtask

  task automatic test_single();
    func_ready = 1'b1;
    load_word(8'h06);
    pulse_start();
    n_checks++;
    if (func_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_fetch: got val=%0b busy=%0b want 0 1", func_valid, busy);
    end
    tick();
    n_checks++;
    if (func_valid !== 1'b1 || func_out !== 4'h6) begin
      n_fail++; $display("FAIL single_issue: got val=%0b out=%h want 1 6", func_valid, func_out);
    end
    tick();
    exp_count = exp_count + 16'd1;
    n_checks++;
    if (func_valid !== 1'b0 || issue_count !== exp_count) begin
      n_fail++; $display("FAIL single_done: got val=%0b cnt=%0d want 0 %0d", func_valid, issue_count, exp_count);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || func_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got busy=%0b val=%0b want 0 0", busy, func_valid);
    end
  endtask

  task automatic test_backpressure();
    func_ready = 1'b0;
    load_word(8'h23);
    pulse_start();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (func_valid !== 1'b1 || func_out !== 4'h3 || issue_count !== exp_count) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got val=%0b out=%h cnt=%0d want 1 3 %0d",
                 i, func_valid, func_out, issue_count, exp_count);
      end
      tick();
    end
    func_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_count = exp_count + 16'd1;
      n_checks++;
      if (issue_count !== exp_count || func_valid !== (i < 2) || func_out !== 4'h3) begin
        n_fail++;
        $display("FAIL bp_hs%0d: got cnt=%0d val=%0b out=%h want %0d %0b 3",
                 i, issue_count, func_valid, func_out, exp_count, (i < 2));
      end
    end
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || issue_count !== exp_count) begin
      n_fail++; $display("FAIL bp_idle: got busy=%0b cnt=%0d want 0 %0d", busy, issue_count, exp_count);
    end
  endtask

  task automatic test_halt();
    int saw_halt_code;
    int n_issued;
    saw_halt_code = 0;
    n_issued = 0;
    func_ready = 1'b1;
    load_word(8'h01);
    load_word(8'h0F);
    load_word(8'h02);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (func_valid && func_out == 4'hF) saw_halt_code++;
      if (func_valid) n_issued++;
      tick();
    end
    exp_count = exp_count + 16'd1;
    n_checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || func_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_state: got halt=%0b busy=%0b val=%0b want 1 0 0", halted, busy, func_valid);
    end
    n_checks++;
    if (n_issued !== 1 || issue_count !== exp_count || saw_halt_code !== 0) begin
      n_fail++;
      $display("FAIL halt_issued: got n=%0d cnt=%0d halt_seen=%0d want 1 %0d 0",
               n_issued, issue_count, saw_halt_code, exp_count);
    end
    pulse_start();
    n_checks++;
    if (halted !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL resume: got halt=%0b busy=%0b want 0 1", halted, busy);
    end
    tick();
    n_checks++;
    if (func_valid !== 1'b1 || func_out !== 4'h2) begin
      n_fail++; $display("FAIL resume_issue: got val=%0b out=%h want 1 2", func_valid, func_out);
    end
    tick();
    tick();
    exp_count = exp_count + 16'd1;
    n_checks++;
    if (issue_count !== exp_count || busy !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_done: got cnt=%0d busy=%0b halt=%0b want %0d 0 0", issue_count, busy, halted, exp_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [3:0] got [8];
    int n_got;
    int budget;
    func_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_word({4'h0, 4'(i)});
      n_checks++;
      if (load_ready !== (i < 7)) begin
        n_fail++; $display("FAIL full_ready%0d: got %0b want %0b", i, load_ready, (i < 7));
      end
    end
    load_word(8'h09);
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ninth: got rdy=%0b want 0", load_ready);
    end
    pulse_start();
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_before_pop: got rdy=%0b want 0", load_ready);
    end
    tick();
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_after_pop: got rdy=%0b want 1", load_ready);
    end
    n_got = 0;
    budget = 0;
    while (n_got < 9 && budget < 60) begin
      if (func_valid) begin
        if (n_got < 8) got[n_got] = func_out;
        n_got++;
      end
      tick();
      budget++;
    end
    n_checks++;
    if (n_got !== 8) begin
      n_fail++; $display("FAIL full_count: got %0d issued want 8", n_got);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i < n_got && got[i] !== 4'(i)) begin
        n_fail++; $display("FAIL full_order%0d: got %h want %h", i, got[i], 4'(i));
      end else if (i >= n_got) begin
        n_fail++; $display("FAIL full_order%0d: missing want %h", i, 4'(i));
      end
    end
    exp_count = exp_count + 16'd8;
    n_checks++;
    if (issue_count !== exp_count || busy !== 1'b0) begin
      n_fail++; $display("FAIL full_done: got cnt=%0d busy=%0b want %0d 0", issue_count, busy, exp_count);
    end
  endtask

  task automatic test_empty_start();
    int busy_cycles;
    int valid_cycles;
    busy_cycles = 0;
    valid_cycles = 0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      if (busy) busy_cycles++;
      if (func_valid) valid_cycles++;
      tick();
    end
    n_checks++;
    if (busy_cycles !== 1 || valid_cycles !== 0) begin
      n_fail++; $display("FAIL empty_start: got busy_cyc=%0d valid_cyc=%0d want 1 0", busy_cycles, valid_cycles);
    end
  endtask

  task automatic test_reset_mid_issue();
    int valid_cycles;
    valid_cycles = 0;
    func_ready = 1'b0;
    load_word(8'h36);
    load_word(8'h05);
    pulse_start();
    tick();
    func_ready = 1'b1;
    tick();
    func_ready = 1'b0;
    n_checks++;
    if (func_valid !== 1'b1 || issue_count !== exp_count + 16'd1) begin
      n_fail++;
      $display("FAIL mid_pre: got val=%0b cnt=%0d want 1 %0d", func_valid, issue_count, exp_count + 16'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (func_valid !== 1'b0 || issue_count !== 16'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got val=%0b cnt=%0d busy=%0b want 0 0 0", func_valid, issue_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_ready: got %0b want 1", load_ready);
    end
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      if (func_valid) valid_cycles++;
      tick();
    end
    n_checks++;
    if (valid_cycles !== 0 || issue_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_flushed: got valid_cyc=%0d cnt=%0d want 0 0", valid_cycles, issue_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_count = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_halt();
    test_fifo_full();
    test_empty_start();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
